mby_msh_bank_arb: RTL and testbench
===================================

# mby_msh_bank_arb

Per-node memory-bank arbiter for the mesh node datapath. Eight requesters (northbound/southbound/eastbound/westbound write and read ports) compete for `NUM_BANKS` single-ported memory banks. The arbiter grants at most one requester per bank per cycle using per-bank round-robin, then registers the winning bank-select controls that steer the node's write, read and memory datapath muxes.

## Interface
Parameters:
- `NUM_REQ`, 8: requester count. Fixed order: 0..3 = wr N,S,E,W; 4..7 = rd N,S,E,W.
- `NUM_BANKS`, 4: memory banks per node. Must be a power of 2, ≥2.
- `BANK_W`, `$clog2(NUM_BANKS)`: bank index width.
- `REQ_W`, `$clog2(NUM_REQ)`: requester index width.
- `STARVE_LIMIT`, 15: wait cycles before a requester turns urgent. Used only with the starvation feature.

Ports:
- `mclk` in 1: mesh clock; the only clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_req_vld` in `NUM_REQ`: request valid, one bit per requester.
- `i_req_bank` in `NUM_REQ*BANK_W`: target bank; requester r occupies bits [r*BANK_W +: BANK_W].
- `i_bank_stall` in `NUM_BANKS`: bank unavailable this cycle, e.g. refresh or ECC scrub.
- `o_req_gnt` out `NUM_REQ`: combinational grant. A transfer happens when `vld & gnt`.
- `o_bank_en` out `NUM_BANKS`: registered bank access enable.
- `o_bank_wr` out `NUM_BANKS`: registered access type; 1 = write, 0 = read.
- `o_bank_src` out `NUM_BANKS*REQ_W`: registered winning requester index per bank.
- `o_starve` out `NUM_REQ`: registered urgent flag per requester.

## Operation
- **Request rule:** a requester holds `vld` and `bank` stable until it is granted. It may present a new request in the cycle after a grant, or in the grant cycle itself for back-to-back transfers.
- **Arbitration:** bank b's candidates are requesters with `vld=1`, `bank==b` and `i_bank_stall[b]=0`.
  - The winner is the first candidate at or after `rr_ptr[b]`, scanning upward modulo `NUM_REQ`.
  - `o_req_gnt[winner]=1`. At most one grant per bank per cycle, and each requester receives at most one grant.
- **Pointer update:**
  - On a grant, `rr_ptr[b] <= winner+1`, wrapping from 7 to 0.
  - With no grant or with the bank stalled, `rr_ptr[b]` holds.
- **Registered controls:** one cycle after a grant, `o_bank_en[b]=1`, `o_bank_src[b]=winner`, `o_bank_wr[b]=(winner<4)`. With no grant, `o_bank_en[b]=0` and `o_bank_src`/`o_bank_wr` hold their previous values.
- **Stall:** a stall suppresses grants only to that bank. Requests to other banks proceed in the same cycle.
- **Reset:** while `i_reset=1`:
  - `o_req_gnt=0`, forced combinationally.
  - The registered outputs `o_bank_en`, `o_bank_wr`, `o_bank_src` and `o_starve` all go to 0 on the next edge.
  - `rr_ptr` goes to 0 on the next edge.
  - The starvation wait counters go to 0 on the next edge.
  - A request in flight when reset asserts is not granted. The requester re-presents it after reset.

## Timing
- **Grant latency:** 0 cycles. `o_req_gnt` is combinational from `i_req_vld`, `i_req_bank`, `i_bank_stall` and registered state.
- **Control latency:** the bank controls appear 1 cycle after the grant cycle.
- **Throughput:** one access per bank per cycle. With N requesters contending continuously for one bank, each is served once every N cycles; with 8 requesters, that is once every 8 cycles.
- **Reset values:** all outputs are 0 in the first cycle after the reset edge.

## Configuration
Macro `MBY_MSH_BANK_ARB_STARVE_EN` controls the starvation guard.

Defined:
- **Counter:** each requester has a saturating 4-bit wait counter (`$clog2(STARVE_LIMIT+1)` bits).
  - Increments each cycle the requester has `vld=1` and `gnt=0`.
  - Clears on a grant or when `vld=0`.
- **Urgent flag:** `o_starve[r]` is registered and set when the counter equals `STARVE_LIMIT`.
- **Priority:** per bank, urgent candidates beat non-urgent ones. Within each class, arbitration is round-robin from `rr_ptr[b]`.

Undefined:
- No counters are built.
- `o_starve` is tied to 0.
- Arbitration is pure round-robin.

## Test plan
- **Distinct banks:**
  - Stimulus: after reset, `vld=0x0F` with wr N,S,E,W targeting banks 0,1,2,3.
  - Response: `gnt=0x0F` in the same cycle; next cycle `o_bank_en=0xF`, `o_bank_wr=0xF`, `o_bank_src={3,2,1,0}`.
- **Full contention:**
  - Stimulus: all 8 requesters hold `vld` for bank 2.
  - Response: grants in order 0,1,…,7, then 0, one per cycle; `o_bank_src[2]` follows one cycle later; `o_bank_wr[2]` is 1 for sources 0-3 and 0 for 4-7.
- **Stall:**
  - Stimulus: `i_bank_stall=0x4` for 3 cycles, with requesters 1 and 5 on bank 2 and requester 6 on bank 0.
  - Response: only requester 6 is granted; bank 2 gets no grants and its pointer is unchanged; after the stall drops, requester 1 wins, then requester 5.
- **Reset mid-operation:**
  - Stimulus: assert `i_reset` for 1 cycle during the full-contention test.
  - Response: `gnt=0` in that cycle; the next grant goes to requester 0 and `o_bank_en=0` in the cycle after reset.
- **Starvation (`STARVE_EN` defined):**
  - Stimulus: requester 7 on bank 1 with `STARVE_LIMIT=2`, while requesters 0-6 are force-rotated onto bank 1 at higher pointer priority.
  - Response: `o_starve[7]` rises once requester 7 has waited 2 cycles; requester 7 is granted next; the flag clears the cycle after the grant.
- **Starvation disabled:**
  - Stimulus: same as the previous scenario, with `STARVE_EN` undefined.
  - Response: `o_starve` stays 0 and pure round-robin order is kept.

Source files
------------

// File: rtl/mby_msh_bank_arb_if.sv
// Requester/bank handshake bundle for the mesh-node bank arbiter.
interface mby_msh_bank_arb_if #(
  parameter int NUM_REQ   = 8,
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = $clog2(NUM_BANKS),
  parameter int REQ_W     = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]         i_req_vld;
  logic [NUM_REQ*BANK_W-1:0]  i_req_bank;
  logic [NUM_BANKS-1:0]       i_bank_stall;
  logic [NUM_REQ-1:0]         o_req_gnt;
  logic [NUM_BANKS-1:0]       o_bank_en;
  logic [NUM_BANKS-1:0]       o_bank_wr;
  logic [NUM_BANKS*REQ_W-1:0] o_bank_src;
  logic [NUM_REQ-1:0]         o_starve;

  modport master (
    output i_req_vld, i_req_bank, i_bank_stall,
    input  o_req_gnt, o_bank_en, o_bank_wr, o_bank_src, o_starve
  );

  modport slave (
    input  i_req_vld, i_req_bank, i_bank_stall,
    output o_req_gnt, o_bank_en, o_bank_wr, o_bank_src, o_starve
  );
endinterface

// File: rtl/mby_msh_bank_arb.sv
// Per-bank round-robin arbiter driving registered bank-select controls.
// Optional starvation guard enabled by MBY_MSH_BANK_ARB_STARVE_EN.
module mby_msh_bank_arb_bank #(
  parameter int NUM_REQ = 8,
  parameter int REQ_W   = $clog2(NUM_REQ)
) (
  input  logic               mclk,
  input  logic               i_reset,
  input  logic [NUM_REQ-1:0] cand_i,
  input  logic [NUM_REQ-1:0] urg_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               en_q_o,
  output logic               wr_q_o,
  output logic [REQ_W-1:0]   src_q_o
);
  logic [REQ_W-1:0]   ptr_q, ptr_d, win;
  logic [NUM_REQ-1:0] pool;
  logic               hit;
  int                 idx;

  always_comb begin
    // urgent candidates form their own round-robin class ahead of the rest
    pool  = (|(cand_i & urg_i)) ? (cand_i & urg_i) : cand_i;
    hit   = 1'b0;
    win   = '0;
    idx   = 0;
    gnt_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!hit && pool[idx]) begin
        hit = 1'b1;
        win = REQ_W'(idx);
      end
    end
    if (hit) gnt_o[win] = 1'b1;
    ptr_d = ptr_q;
    if (hit) ptr_d = (win == REQ_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge mclk) begin
    if (i_reset) begin
      ptr_q   <= '0;
      en_q_o  <= 1'b0;
      wr_q_o  <= 1'b0;
      src_q_o <= '0;
    end else begin
      ptr_q  <= ptr_d;
      en_q_o <= hit;
      if (hit) begin
        src_q_o <= win;
        wr_q_o  <= (int'(win) < NUM_REQ/2);
      end
    end
  end
endmodule

module mby_msh_bank_arb #(
  parameter int NUM_REQ      = 8,
  parameter int NUM_BANKS    = 4,
  parameter int BANK_W       = $clog2(NUM_BANKS),
  parameter int REQ_W        = $clog2(NUM_REQ),
  parameter int STARVE_LIMIT = 15
) (
  input logic                mclk,
  input logic                i_reset,
  mby_msh_bank_arb_if.slave  bus
);
  logic [NUM_BANKS-1:0][NUM_REQ-1:0] cand, bank_gnt;
  logic [NUM_BANKS-1:0][REQ_W-1:0]   src;
  logic [NUM_BANKS-1:0]              en, wr;
  logic [NUM_REQ-1:0]                gnt, urg;

  // reset masks every candidate so no grant leaks out while it is held
  always_comb begin
    cand = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      for (int r = 0; r < NUM_REQ; r++)
        cand[b][r] = bus.i_req_vld[r] && !bus.i_bank_stall[b] && !i_reset &&
                     (bus.i_req_bank[r*BANK_W +: BANK_W] == BANK_W'(b));
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mby_msh_bank_arb_bank #(.NUM_REQ(NUM_REQ), .REQ_W(REQ_W)) u_bank (
      .mclk    (mclk),
      .i_reset (i_reset),
      .cand_i  (cand[b]),
      .urg_i   (urg),
      .gnt_o   (bank_gnt[b]),
      .en_q_o  (en[b]),
      .wr_q_o  (wr[b]),
      .src_q_o (src[b])
    );
  end

  always_comb begin
    gnt = '0;
    for (int b = 0; b < NUM_BANKS; b++) gnt |= bank_gnt[b];
  end

  assign bus.o_req_gnt  = gnt;
  assign bus.o_bank_en  = en;
  assign bus.o_bank_wr  = wr;
  assign bus.o_bank_src = src;

`ifdef MBY_MSH_BANK_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT+1);
  logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0]            starve_q, starve_d;

  always_comb begin
    cnt_d    = cnt_q;
    starve_d = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (!bus.i_req_vld[r] || gnt[r])          cnt_d[r] = '0;
      else if (cnt_q[r] != CNT_W'(STARVE_LIMIT)) cnt_d[r] = cnt_q[r] + 1'b1;
      starve_d[r] = (cnt_d[r] == CNT_W'(STARVE_LIMIT));
    end
  end

  always_ff @(posedge mclk) begin
    if (i_reset) begin
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  assign urg          = starve_q;
  assign bus.o_starve = starve_q;
`else
  assign urg          = '0;
  assign bus.o_starve = '0;
`endif
endmodule

// File: tb/tb_mby_msh_bank_arb.sv
// Randomized + directed bench for mby_msh_bank_arb against a distance-based arbitration model.
module tb_mby_msh_bank_arb;
  localparam int NR = 8, NB = 4, BW = 2, RW = 3, SL = 2;
`ifdef MBY_MSH_BANK_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic mclk = 1'b0;
  logic i_reset = 1'b1;
  always #5 mclk = ~mclk;

  logic [NR-1:0]    vld = '0;
  logic [NR*BW-1:0] bnk_flat = '0;
  logic [NB-1:0]    stall = '0;

  mby_msh_bank_arb_if #(.NUM_REQ(NR), .NUM_BANKS(NB)) bus();
  assign bus.i_req_vld    = vld;
  assign bus.i_req_bank   = bnk_flat;
  assign bus.i_bank_stall = stall;

  mby_msh_bank_arb #(.NUM_REQ(NR), .NUM_BANKS(NB), .STARVE_LIMIT(SL)) dut (
    .mclk(mclk), .i_reset(i_reset), .bus(bus));

  int n_chk = 0, n_fail = 0;

  // model state
  int               m_ptr [NB];
  int               m_cnt [NR];
  logic [NR-1:0]    m_starve = '0;
  logic [NB-1:0]    m_en = '0, m_wr = '0;
  logic [NB*RW-1:0] m_src = '0;
  logic [NR-1:0]    eg;

  // winner = candidate nearest at/after the pointer; urgent class first
  function automatic logic [NR-1:0] model_gnt();
    logic [NR-1:0] g;
    int best, bestd, d;
    bit bestu, u;
    g = '0;
    if (i_reset) return g;
    for (int b = 0; b < NB; b++) begin
      best = -1; bestd = NR; bestu = 1'b0;
      for (int r = 0; r < NR; r++) begin
        if (vld[r] && bnk_flat[r*BW +: BW] == BW'(b) && !stall[b]) begin
          u = STARVE && m_starve[r];
          d = (r - m_ptr[b] + NR) % NR;
          if ((u && !bestu) || (u == bestu && d < bestd)) begin
            best = r; bestd = d; bestu = u;
          end
        end
      end
      if (best >= 0) g[best] = 1'b1;
    end
    return g;
  endfunction

  task automatic model_tick(input logic [NR-1:0] g);
    if (i_reset) begin
      for (int b = 0; b < NB; b++) m_ptr[b] = 0;
      for (int r = 0; r < NR; r++) m_cnt[r] = 0;
      m_starve = '0; m_en = '0; m_wr = '0; m_src = '0;
      return;
    end
    for (int r = 0; r < NR; r++) begin
      if (vld[r] && !g[r]) m_cnt[r] = (m_cnt[r] < SL) ? m_cnt[r] + 1 : SL;
      else m_cnt[r] = 0;
      m_starve[r] = STARVE && (m_cnt[r] == SL);
    end
    for (int b = 0; b < NB; b++) begin
      m_en[b] = 1'b0;
      for (int r = 0; r < NR; r++)
        if (g[r] && bnk_flat[r*BW +: BW] == BW'(b)) begin
          m_en[b] = 1'b1;
          m_wr[b] = (r < NR/2);
          m_src[b*RW +: RW] = RW'(r);
          m_ptr[b] = (r + 1) % NR;
        end
    end
  endtask

  task automatic advance(input logic [NR-1:0] g);
    @(posedge mclk);
    model_tick(g);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1; vld = '0; stall = '0;
    advance('0);
    i_reset = 1'b0;
  endtask

  task automatic set_bank(input int r, input int b);
    bnk_flat[r*BW +: BW] = BW'(b);
  endtask

  task automatic test_reset();
    i_reset = 1'b1; vld = '1; bnk_flat = '0;
    @(negedge mclk);
    n_chk++;
    if (bus.o_req_gnt !== '0) begin n_fail++; $display("FAIL reset_gnt: got %h want 00", bus.o_req_gnt); end
    advance('0);
    @(negedge mclk);
    n_chk++;
    if ({bus.o_bank_en, bus.o_bank_wr, bus.o_bank_src, bus.o_starve} !== '0) begin
      n_fail++; $display("FAIL reset_regs: en=%h wr=%h src=%h starve=%h want all 0",
                         bus.o_bank_en, bus.o_bank_wr, bus.o_bank_src, bus.o_starve);
    end
    advance('0);
    i_reset = 1'b0; vld = '0;
  endtask

  task automatic test_distinct_banks();
    vld = 8'h0F;
    for (int r = 0; r < 4; r++) set_bank(r, r);
    @(negedge mclk);
    eg = model_gnt();
    n_chk++;
    if (bus.o_req_gnt !== 8'h0F || eg !== 8'h0F) begin
      n_fail++; $display("FAIL distinct_gnt: got %h model %h want 0f", bus.o_req_gnt, eg);
    end
    advance(eg);
    vld = '0;
    @(negedge mclk);
    n_chk++;
    if (bus.o_bank_en !== 4'hF || bus.o_bank_wr !== 4'hF || bus.o_bank_src !== 12'h688) begin
      n_fail++; $display("FAIL distinct_regs: en=%h wr=%h src=%h want f f 688",
                         bus.o_bank_en, bus.o_bank_wr, bus.o_bank_src);
    end
    advance('0);
  endtask

  task automatic test_full_contention();
    do_reset();
    vld = '1;
    for (int r = 0; r < NR; r++) set_bank(r, 2);
    for (int k = 0; k < 10; k++) begin
      @(negedge mclk);
      eg = model_gnt();
      n_chk++;
      if (bus.o_req_gnt !== NR'(1 << (k % NR)) || bus.o_req_gnt !== eg) begin
        n_fail++; $display("FAIL contention_gnt[%0d]: got %h model %h", k, bus.o_req_gnt, eg);
      end
      if (k > 0) begin
        n_chk++;
        if (bus.o_bank_en[2] !== 1'b1 || bus.o_bank_src[2*RW +: RW] !== RW'((k-1) % NR) ||
            bus.o_bank_wr[2] !== (((k-1) % NR) < 4)) begin
          n_fail++; $display("FAIL contention_ctl[%0d]: en=%b src=%0d wr=%b want 1 %0d %b", k,
                             bus.o_bank_en[2], bus.o_bank_src[2*RW +: RW], bus.o_bank_wr[2],
                             (k-1) % NR, ((k-1) % NR) < 4);
        end
      end
      advance(eg);
    end
    vld = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    vld = '1;
    for (int r = 0; r < NR; r++) set_bank(r, 2);
    for (int k = 0; k < 3; k++) begin
      @(negedge mclk); eg = model_gnt(); advance(eg);
    end
    i_reset = 1'b1;
    @(negedge mclk);
    n_chk++;
    if (bus.o_req_gnt !== '0) begin n_fail++; $display("FAIL midreset_gnt: got %h want 00", bus.o_req_gnt); end
    advance('0);
    i_reset = 1'b0;
    @(negedge mclk);
    eg = model_gnt();
    n_chk++;
    if (bus.o_req_gnt !== 8'h01 || bus.o_bank_en !== 4'h0) begin
      n_fail++; $display("FAIL midreset_after: gnt=%h en=%h want 01 0", bus.o_req_gnt, bus.o_bank_en);
    end
    advance(eg);
    vld = '0;
  endtask

  task automatic test_stall();
    logic [NR-1:0] want [6];
    want = '{8'h40, 8'h00, 8'h00, 8'h02, 8'h20, 8'h00};
    do_reset();
    vld = 8'h62; set_bank(1, 2); set_bank(5, 2); set_bank(6, 0);
    stall = 4'h4;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) stall = '0;
      @(negedge mclk);
      eg = model_gnt();
      n_chk++;
      if (bus.o_req_gnt !== want[k] || bus.o_req_gnt !== eg) begin
        n_fail++; $display("FAIL stall_gnt[%0d]: got %h model %h want %h", k, bus.o_req_gnt, eg, want[k]);
      end
      n_chk++;
      if ({bus.o_bank_en, bus.o_bank_wr, bus.o_bank_src} !== {m_en, m_wr, m_src}) begin
        n_fail++; $display("FAIL stall_regs[%0d]: got %h want %h", k,
                           {bus.o_bank_en, bus.o_bank_wr, bus.o_bank_src}, {m_en, m_wr, m_src});
      end
      advance(eg);
      vld &= ~eg;
    end
    stall = '0;
  endtask

  task automatic test_starvation();
    logic [NR-1:0] pend;
    do_reset();
    pend = 8'h80;
    for (int r = 0; r < NR; r++) set_bank(r, 1);
    for (int c = 0; c < 10; c++) begin
      if (c < 7) pend[c] = 1'b1;
      vld = pend;
      @(negedge mclk);
      eg = model_gnt();
      n_chk++;
      if (bus.o_req_gnt !== eg || bus.o_starve !== m_starve) begin
        n_fail++; $display("FAIL starve_model[%0d]: gnt=%h starve=%h want %h %h", c,
                           bus.o_req_gnt, bus.o_starve, eg, m_starve);
      end
      if (c == 2) begin
        n_chk++;
        if (bus.o_req_gnt !== (STARVE ? 8'h80 : 8'h04) || bus.o_starve[7] !== STARVE) begin
          n_fail++; $display("FAIL starve_c2: gnt=%h starve7=%b want %h %b", bus.o_req_gnt,
                             bus.o_starve[7], STARVE ? 8'h80 : 8'h04, STARVE);
        end
      end
      if (c == 3) begin
        n_chk++;
        if (bus.o_starve[7] !== 1'b0) begin
          n_fail++; $display("FAIL starve_clear: got %b want 0", bus.o_starve[7]);
        end
      end
      advance(eg);
      pend &= ~eg;
    end
    vld = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge mclk);
      eg = model_gnt();
      n_chk++;
      if (bus.o_req_gnt !== eg) begin
        n_fail++; $display("FAIL rand_gnt[%0d]: got %h want %h", c, bus.o_req_gnt, eg);
      end
      n_chk++;
      if ({bus.o_bank_en, bus.o_bank_wr, bus.o_bank_src, bus.o_starve} !== {m_en, m_wr, m_src, m_starve}) begin
        n_fail++; $display("FAIL rand_regs[%0d]: got %h want %h", c,
                           {bus.o_bank_en, bus.o_bank_wr, bus.o_bank_src, bus.o_starve},
                           {m_en, m_wr, m_src, m_starve});
      end
      advance(eg);
      if (i_reset) vld = '0;
      else vld &= ~eg;
      for (int r = 0; r < NR; r++)
        if (!vld[r] && ($urandom % 2 == 0)) begin
          vld[r] = 1'b1;
          set_bank(r, int'($urandom % NB));
        end
      stall   = ($urandom % 4 == 0) ? NB'($urandom) : '0;
      i_reset = ($urandom % 64 == 0);
    end
    i_reset = 1'b0; vld = '0; stall = '0;
  endtask

  initial begin
    test_reset();
    test_distinct_banks();
    test_full_contention();
    test_reset_mid();
    test_stall();
    test_starvation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
